// File: rtl/bpf_pkg.sv
// Shared FSM/MAC encodings, reset coefficients and the saturating resize
// helper for the time-multiplexed band-pass biquad.
package bpf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A1,
        S_A2,
        S_B,
        S_WR,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MAC_HOLD,
        MAC_LOAD,
        MAC_SUBSHR,
        MAC_ADD
    } mac_op_t;

    localparam int DEF_A1 = 457;
    localparam int DEF_A2 = 238;
    localparam int DEF_B  = 9;

    localparam int unsigned WIDE_W = 64;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [WIDE_W-1:0] sat_resize(
        input logic signed [WIDE_W-1:0] v,
        input int unsigned              w
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/bpf_mac.sv
// Single shared signed multiplier with an accumulator: load, subtract-then-
// floor-shift, or add the product coef * operand.
module bpf_mac
    import bpf_pkg::*;
#(
    parameter int unsigned ACC_W  = 22,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned EXT_W  = ACC_W + COEF_W + 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  mac_op_t                  op,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [ACC_W-1:0]  operand,
    output logic signed [EXT_W-1:0]  acc
);

    localparam int unsigned PROD_W = COEF_W + ACC_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [EXT_W-1:0]  prod_ext;

    assign prod     = PROD_W'(coef) * PROD_W'(operand);
    assign prod_ext = EXT_W'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            case (op)
                MAC_LOAD:   acc <= prod_ext;
                MAC_SUBSHR: acc <= (acc - prod_ext) >>> FRAC;
                MAC_ADD:    acc <= acc + prod_ext;
                default:    acc <= acc;
            endcase
        end
    end

endmodule

// File: rtl/bpf_biquad_mux.sv
// Time-multiplexed band-pass biquad: CH channels share one MAC, four cycles
// per channel, with run-time coefficients, saturation and sticky flags.
module bpf_biquad_mux
    import bpf_pkg::*;
#(
    parameter int unsigned IN_W   = 13,
    parameter int unsigned ACC_W  = 22,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned COEF_W = 12,
    parameter int unsigned CH     = 4,
    parameter int unsigned OUT_W  = ACC_W - FRAC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH*IN_W-1:0]       in_data,
    input  logic                     coef_we,
    input  logic signed [COEF_W-1:0] coef_a1,
    input  logic signed [COEF_W-1:0] coef_a2,
    input  logic signed [COEF_W-1:0] coef_b,
    input  logic                     sat_clr,
    output logic                     out_valid,
    output logic [CH*OUT_W-1:0]      out_data,
    output logic [CH*OUT_W-1:0]      out_delay,
    output logic [CH-1:0]            sat_flag
);

    localparam int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned EXT_W  = ACC_W + COEF_W + 2;
    localparam int unsigned DIFF_W = IN_W + 1;

    state_t                    state;
    logic [CH_W-1:0]           ch;

    logic signed [IN_W-1:0]    x_cur [CH];
    logic signed [IN_W-1:0]    x1    [CH];
    logic signed [IN_W-1:0]    x2    [CH];
    logic signed [ACC_W-1:0]   u1    [CH];
    logic signed [ACC_W-1:0]   u2    [CH];

    logic signed [COEF_W-1:0]  sh_a1, sh_a2, sh_b;
    logic signed [COEF_W-1:0]  act_a1, act_a2, act_b;

    mac_op_t                   mac_op;
    logic signed [COEF_W-1:0]  mac_coef;
    logic signed [ACC_W-1:0]   mac_opnd;
    logic signed [EXT_W-1:0]   mac_acc;
    logic signed [DIFF_W-1:0]  x_diff;

    logic signed [WIDE_W-1:0]  acc_wide;
    logic signed [WIDE_W-1:0]  acc_sat_wide;
    logic signed [ACC_W-1:0]   acc_sat;
    logic                      clamped;

    assign x_diff       = DIFF_W'(x_cur[ch]) - DIFF_W'(x2[ch]);
    assign acc_wide     = WIDE_W'(mac_acc);
    assign acc_sat_wide = sat_resize(acc_wide, ACC_W);
    assign acc_sat      = ACC_W'(acc_sat_wide);
    assign clamped      = (acc_sat_wide != acc_wide);

    // Steer coefficient and operand into the shared MAC for each phase.
    always_comb begin
        mac_op   = MAC_HOLD;
        mac_coef = act_a1;
        mac_opnd = u1[ch];
        case (state)
            S_A1: begin
                mac_op   = MAC_LOAD;
                mac_coef = act_a1;
                mac_opnd = u1[ch];
            end
            S_A2: begin
                mac_op   = MAC_SUBSHR;
                mac_coef = act_a2;
                mac_opnd = u2[ch];
            end
            S_B: begin
                mac_op   = MAC_ADD;
                mac_coef = act_b;
                mac_opnd = ACC_W'(x_diff);
            end
            default: ;
        endcase
    end

    bpf_mac #(
        .ACC_W  (ACC_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .EXT_W  (EXT_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (mac_op),
        .coef    (mac_coef),
        .operand (mac_opnd),
        .acc     (mac_acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ch        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_delay <= '0;
            sat_flag  <= '0;
            sh_a1     <= COEF_W'(DEF_A1);
            sh_a2     <= COEF_W'(DEF_A2);
            sh_b      <= COEF_W'(DEF_B);
            act_a1    <= COEF_W'(DEF_A1);
            act_a2    <= COEF_W'(DEF_A2);
            act_b     <= COEF_W'(DEF_B);
            for (int c = 0; c < CH; c++) begin
                x_cur[c] <= '0;
                x1[c]    <= '0;
                x2[c]    <= '0;
                u1[c]    <= '0;
                u2[c]    <= '0;
            end
        end else begin
            out_valid <= 1'b0;

            if (coef_we) begin
                sh_a1 <= coef_a1;
                sh_a2 <= coef_a2;
                sh_b  <= coef_b;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE) begin
                        out_valid <= 1'b1;
                        out_delay <= out_data;
                        for (int c = 0; c < CH; c++) begin
                            out_data[c*OUT_W +: OUT_W] <= u1[c][ACC_W-1:FRAC];
                        end
                    end
                    // DONE doubles as an accept slot for back-to-back frames.
                    if (in_valid) begin
                        for (int c = 0; c < CH; c++) begin
                            x_cur[c] <= in_data[c*IN_W +: IN_W];
                        end
                        act_a1   <= sh_a1;
                        act_a2   <= sh_a2;
                        act_b    <= sh_b;
                        ch       <= '0;
                        in_ready <= 1'b0;
                        state    <= S_A1;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_A1: state <= S_A2;
                S_A2: state <= S_B;
                S_B:  state <= S_WR;
                S_WR: begin
                    u2[ch] <= u1[ch];
                    u1[ch] <= acc_sat;
                    x2[ch] <= x1[ch];
                    x1[ch] <= x_cur[ch];
                    if (clamped) begin
                        sat_flag[ch] <= 1'b1;
                    end
                    if (ch == CH_W'(CH - 1)) begin
                        in_ready <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        ch    <= ch + CH_W'(1);
                        state <= S_A1;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase

            // Clear wins over a same-cycle set.
            if (sat_clr) begin
                sat_flag <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bpf_biquad_mux.sv
// Directed self-checking bench for bpf_biquad_mux against a floor-arithmetic
// behavioural model of the band-pass recursion.
module tb_bpf_biquad_mux;

    localparam int unsigned IN_W   = 13;
    localparam int unsigned ACC_W  = 22;
    localparam int unsigned FRAC   = 8;
    localparam int unsigned COEF_W = 12;
    localparam int unsigned CH     = 4;
    localparam int unsigned OUT_W  = ACC_W - FRAC;
    localparam longint AMAX = 2097151;
    localparam longint AMIN = -2097152;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [CH*IN_W-1:0]     in_data;
    logic                   coef_we;
    logic [COEF_W-1:0]      coef_a1, coef_a2, coef_b;
    logic                   sat_clr;
    logic                   out_valid;
    logic [CH*OUT_W-1:0]    out_data;
    logic [CH*OUT_W-1:0]    out_delay;
    logic [CH-1:0]          sat_flag;

    always #5 clk = ~clk;

    bpf_biquad_mux dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_a1   (coef_a1),
        .coef_a2   (coef_a2),
        .coef_b    (coef_b),
        .sat_clr   (sat_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_delay (out_delay),
        .sat_flag  (sat_flag)
    );

    int total = 0;
    int bad   = 0;

    longint mu1 [CH];
    longint mu2 [CH];
    longint mx1 [CH];
    longint mx2 [CH];
    longint mout[CH];
    longint mdel[CH];
    longint ma1, ma2, mb, msa1, msa2, msb;
    logic [CH-1:0] mflag;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] lane(input logic [CH*OUT_W-1:0] v, input int c);
        logic signed [OUT_W-1:0] s;
        s = v[c*OUT_W +: OUT_W];
        return 64'(s);
    endfunction

    function automatic logic [CH*IN_W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [CH*IN_W-1:0] v;
        v[0*IN_W +: IN_W] = IN_W'(a);
        v[1*IN_W +: IN_W] = IN_W'(b);
        v[2*IN_W +: IN_W] = IN_W'(c);
        v[3*IN_W +: IN_W] = IN_W'(d);
        return v;
    endfunction

    function automatic logic [CH*IN_W-1:0] bb_frame(input int k);
        return pack4(((k * 373 + 0 * 1291) % 8191) - 4095, ((k * 373 + 1 * 1291) % 8191) - 4095,
                     ((k * 373 + 2 * 1291) % 8191) - 4095, ((k * 373 + 3 * 1291) % 8191) - 4095);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mu1[c] = 0; mu2[c] = 0; mx1[c] = 0; mx2[c] = 0; mout[c] = 0; mdel[c] = 0;
        end
        msa1 = 457; msa2 = 238; msb = 9;
        ma1 = 457; ma2 = 238; mb = 9;
        mflag = '0;
    endtask

    task automatic model_step(input logic [CH*IN_W-1:0] din, input bit clr_hold);
        ma1 = msa1; ma2 = msa2; mb = msb;
        for (int c = 0; c < CH; c++) begin
            logic signed [IN_W-1:0] xs;
            longint x;
            longint acc;
            xs  = din[c*IN_W +: IN_W];
            x   = longint'(xs);
            acc = ((ma1 * mu1[c] - ma2 * mu2[c]) >>> FRAC) + mb * (x - mx2[c]);
            if (acc > AMAX) begin
                acc = AMAX;
                if (!clr_hold) mflag[c] = 1'b1;
            end else if (acc < AMIN) begin
                acc = AMIN;
                if (!clr_hold) mflag[c] = 1'b1;
            end
            mu2[c] = mu1[c]; mu1[c] = acc;
            mx2[c] = mx1[c]; mx1[c] = x;
            mdel[c] = mout[c]; mout[c] = acc >>> FRAC;
        end
        if (clr_hold) mflag = '0;
    endtask

    task automatic check_outputs(input string tag);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s.data%0d", tag, c), lane(out_data, c), mout[c]);
            check($sformatf("%s.delay%0d", tag, c), lane(out_delay, c), mdel[c]);
        end
        check({tag, ".sat"}, sat_flag, mflag);
    endtask

    // One frame: accept, optionally pulse coef_we mid-frame, await out_valid.
    task automatic do_frame(input logic [CH*IN_W-1:0] din, input string tag, input int coef_at,
                            input int ca1, input int ca2, input int cb, input bit clr_hold);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, ".rdy"}, in_ready, 1);
        in_data  = din;
        in_valid = 1'b1;
        sat_clr  = clr_hold;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_step(din, clr_hold);
        check({tag, ".busy"}, in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (n == coef_at) begin
                coef_a1 = COEF_W'(ca1);
                coef_a2 = COEF_W'(ca2);
                coef_b  = COEF_W'(cb);
                coef_we = 1'b1;
            end
            @(posedge clk); #1;
            coef_we = 1'b0;
            n++;
        end
        if (coef_at >= 0) begin
            msa1 = ca1; msa2 = ca2; msb = cb;
        end
        sat_clr = 1'b0;
        check({tag, ".lat"}, n, 4 * CH + 1);
        check({tag, ".ov"}, out_valid, 1);
        check_outputs(tag);
        @(posedge clk); #1;
        check({tag, ".pulse"}, out_valid, 0);
        check({tag, ".hold"}, lane(out_data, 0), mout[0]);
    endtask

    task automatic set_coef(input int a1, input int a2, input int b);
        coef_a1 = COEF_W'(a1);
        coef_a2 = COEF_W'(a2);
        coef_b  = COEF_W'(b);
        coef_we = 1'b1;
        @(posedge clk); #1;
        coef_we = 1'b0;
        msa1 = a1; msa2 = a2; msb = b;
    endtask

    task automatic impulse_seq(input string tag);
        do_frame(pack4(1000, 0, 0, 0), {tag, "0"}, -1, 0, 0, 0, 1'b0);
        check({tag, "0.hand"}, lane(out_data, 0), 35);
        check({tag, "0.hdel"}, lane(out_delay, 0), 0);
        do_frame(pack4(0, 0, 0, 0), {tag, "1"}, -1, 0, 0, 0, 1'b0);
        check({tag, "1.hand"}, lane(out_data, 0), 62);
        check({tag, "1.hdel"}, lane(out_delay, 0), 35);
        do_frame(pack4(0, 0, 0, 0), {tag, "2"}, -1, 0, 0, 0, 1'b0);
        check({tag, "2.hand"}, lane(out_data, 0), 44);
        check({tag, "2.hdel"}, lane(out_delay, 0), 62);
        check({tag, "2.ch1"}, lane(out_data, 1), 0);
        check({tag, "2.ch3"}, lane(out_data, 3), 0);
    endtask

    initial begin
        int  pulses;
        int  sq;
        bit  seen_max;
        bit  seen_min;
        longint v;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        coef_we  = 1'b0;
        coef_a1  = '0;
        coef_a2  = '0;
        coef_b   = '0;
        sat_clr  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", in_ready, 1);
        check("rst.ov", out_valid, 0);
        check("rst.data", out_data, 0);
        check("rst.delay", out_delay, 0);
        check("rst.sat", sat_flag, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        impulse_seq("imp");

        for (int k = 0; k < 200; k++) begin
            do_frame(pack4(4000, 4000, 4000, 4000), "dc", -1, 0, 0, 0, 1'b0);
        end
        for (int c = 0; c < CH; c++) begin
            v = lane(out_data, c);
            check($sformatf("dc.small%0d", c), (v >= -1 && v <= 1), 1);
        end
        check("dc.nosat", sat_flag, 0);

        // Coefficients written mid-frame apply from the next frame only.
        do_frame(pack4(3000, -2000, 1500, -500), "cmid", 5, 0, 0, 1, 1'b0);
        do_frame(pack4(-1000, 2500, -3000, 4000), "cnext", -1, 0, 0, 0, 1'b0);
        check("cnext.hand0", lane(out_data, 0), -20);
        check("cnext.hand3", lane(out_data, 3), 0);
        do_frame(pack4(0, 0, 0, 0), "cnext2", -1, 0, 0, 0, 1'b0);
        check("cnext2.hand0", lane(out_data, 0), -12);

        set_coef(457, 238, 2047);
        seen_max = 1'b0;
        seen_min = 1'b0;
        for (int k = 0; k < 12; k++) begin
            sq = ((k % 4) < 2) ? 4095 : -4095;
            do_frame(pack4(sq, -sq, sq, -sq), "sat", -1, 0, 0, 0, 1'b0);
            for (int c = 0; c < CH; c++) begin
                if (lane(out_data, c) == 8191) seen_max = 1'b1;
                if (lane(out_data, c) == -8192) seen_min = 1'b1;
            end
        end
        check("sat.max", seen_max, 1);
        check("sat.min", seen_min, 1);
        check("sat.flag0", sat_flag[0], 1);

        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        mflag = '0;
        check("satclr", sat_flag, 0);
        do_frame(pack4(4095, -4095, 4095, -4095), "sathold", -1, 0, 0, 0, 1'b1);
        check("sathold.flag", sat_flag, 0);
        do_frame(pack4(-4095, 4095, -4095, 4095), "satset", -1, 0, 0, 0, 1'b0);

        // Reset on the seventh edge of a frame discards it.
        in_data  = pack4(2000, -2000, 1000, -1000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst.data", out_data, 0);
        check("mrst.delay", out_delay, 0);
        check("mrst.sat", sat_flag, 0);
        check("mrst.ready", in_ready, 1);
        check("mrst.ov", out_valid, 0);
        rst_n = 1'b1;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) pulses++;
        end
        check("mrst.nopulse", pulses, 0);
        impulse_seq("reimp");

        // Back-to-back: in_valid held high, one frame per 4*CH+1 cycles.
        in_data  = bb_frame(0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 50; k++) begin
            model_step(bb_frame(k), 1'b0);
            if (k == 49) in_valid = 1'b0;
            else in_data = bb_frame(k + 1);
            pulses = 0;
            for (int i = 0; i < 4 * CH + 1; i++) begin
                @(posedge clk); #1;
                if (out_valid === 1'b1 && i != 4 * CH) pulses++;
            end
            check($sformatf("bb%0d.ov", k), out_valid, 1);
            check($sformatf("bb%0d.early", k), pulses, 0);
            check_outputs($sformatf("bb%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
